// File: rtl/types_pkg.sv
// Shared types for the time-of-day path.
//   time_t      : nine 4-bit BCD digits, t_10h in the MSBs down to t_1ms in the LSBs
//   set_state_t : states of the software time-set handshake
//   DIGIT_MAX   : roll-over value of each digit, index 0 = t_1ms .. index 8 = t_10h
//   time_valid  : range check of the hh:mm:ss part of a time_t
package types_pkg;

    typedef struct packed {
        logic [3:0] t_10h;
        logic [3:0] t_1h;
        logic [3:0] t_10m;
        logic [3:0] t_1m;
        logic [3:0] t_10s;
        logic [3:0] t_1s;
        logic [3:0] t_100ms;
        logic [3:0] t_10ms;
        logic [3:0] t_1ms;
    } time_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        ACK  = 2'd2
    } set_state_t;

    localparam logic [3:0] MAX_DEC    = 4'd9;
    localparam logic [3:0] MAX_10S    = 4'd5;
    localparam logic [3:0] MAX_10M    = 4'd5;
    localparam logic [3:0] MAX_10H    = 4'd2;
    // Highest units-of-hours digit once the tens-of-hours digit reaches 2.
    localparam logic [3:0] MAX_1H_20  = 4'd3;

    localparam logic [8:0][3:0] DIGIT_MAX = {
        MAX_10H, MAX_DEC, MAX_10M, MAX_DEC, MAX_10S, MAX_DEC, MAX_DEC, MAX_DEC, MAX_DEC
    };

    function automatic logic time_valid(
        input logic [3:0] t_10h,
        input logic [3:0] t_1h,
        input logic [3:0] t_10m,
        input logic [3:0] t_1m,
        input logic [3:0] t_10s,
        input logic [3:0] t_1s
    );
        logic ok;
        ok = (t_1h <= MAX_DEC) && (t_1m <= MAX_DEC) && (t_1s <= MAX_DEC) &&
             (t_10s <= MAX_10S) && (t_10m <= MAX_10M) && (t_10h <= MAX_10H);
        // 20..23 is the only legal range once the tens digit is 2.
        if (t_10h == MAX_10H && t_1h > MAX_1H_20)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the time-of-day counter.
//   clk, rst  : clock and synchronous active-high reset
//   inc       : advance the digit by one (wraps to 0 after MAX)
//   load      : load load_val, takes priority over inc
//   load_val  : value to load
//   q         : current digit value
//   carry     : inc while the digit sits at MAX, feeds the next digit's inc
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic       carry
);

    assign carry = inc && (q == MAX);

    always_ff @(posedge clk) begin
        if (rst)
            q <= 4'd0;
        else if (load)
            q <= load_val;
        else if (inc)
            q <= (q == MAX) ? 4'd0 : q + 4'd1;
    end

endmodule

// File: rtl/tod_cnt.sv
// BCD time-of-day counter hh:mm:ss.mmm.
//   clk, rst   : 200 MHz clock, synchronous active-high reset
//   tsc_1ppms  : 1-cycle millisecond tick
//   tsc_1pps   : 1-cycle second tick (also counts as a millisecond tick)
//   set_req    : level request to load set_time; set_time stable while high
//   set_time   : time to load, millisecond digits ignored
//   set_ack    : handshake acknowledge
//   set_err    : with set_ack, set_time was rejected
//   cur_time   : current time
//   pps_err    : 1-cycle pulse when 1pps arrived with ms != 999 and ms were snapped
//   pps_lost   : no 1pps seen for PPS_TIMEOUT millisecond ticks
module tod_cnt
    import types_pkg::*;
#(
    parameter int PPS_SYNC    = 1,
    parameter int PPS_TIMEOUT = 1100
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  tsc_1ppms,
    input  logic  tsc_1pps,
    input  logic  set_req,
    input  time_t set_time,
    output logic  set_ack,
    output logic  set_err,
    output time_t cur_time,
    output logic  pps_err,
    output logic  pps_lost
);

    localparam logic [10:0] TIMEOUT = 11'(PPS_TIMEOUT);

    set_state_t      state;
    set_state_t      state_next;
    logic            set_err_next;
    logic            set_load;

    logic            tick;
    logic            adv;
    logic            snap;
    logic            hour_wrap;
    logic            set_ok;
    logic [10:0]     lost_cnt;

    logic [8:0][3:0] q_vec;
    logic [8:0][3:0] set_vec;
    logic [8:0][3:0] ld_val;
    logic [8:0]      inc;
    logic [8:0]      carry;
    logic [8:0]      ld;

    // The millisecond digits of set_time and the top carry have no consumer.
    logic            unused_bits;

    assign set_vec     = set_time;
    assign cur_time    = time_t'(q_vec);
    assign unused_bits = ^{set_vec[2:0], carry[8]};

    assign tick   = tsc_1ppms | tsc_1pps;
    assign adv    = tick && !set_load;
    assign set_ok = time_valid(set_time.t_10h, set_time.t_1h, set_time.t_10m,
                               set_time.t_1m, set_time.t_10s, set_time.t_1s);

    // A 1pps arriving mid-second forces the ms digits to 000 and pushes a
    // carry into the seconds, as if the ms digits had just rolled over.
    assign snap = (PPS_SYNC != 0) && tsc_1pps && !set_load &&
                  !(q_vec[2] == 4'd9 && q_vec[1] == 4'd9 && q_vec[0] == 4'd9);

    assign hour_wrap = inc[7] && (q_vec[8] == MAX_10H) && (q_vec[7] == MAX_1H_20);

    // Carry chain plus the per-digit load selection (set load, 1pps snap on
    // the ms digits, 23->00 wrap on the hour digits).
    always_comb begin
        inc    = '0;
        ld     = '0;
        ld_val = '0;
        inc[0] = adv;
        for (int i = 1; i < 9; i++)
            inc[i] = carry[i-1];
        inc[3] = carry[2] | snap;
        for (int i = 0; i < 3; i++)
            ld[i] = set_load | snap;
        for (int i = 3; i < 7; i++) begin
            ld[i]     = set_load;
            ld_val[i] = set_vec[i];
        end
        for (int i = 7; i < 9; i++) begin
            ld[i]     = set_load | hour_wrap;
            ld_val[i] = set_load ? set_vec[i] : 4'd0;
        end
    end

    for (genvar g = 0; g < 9; g++) begin : g_digit
        bcd_digit #(.MAX(DIGIT_MAX[g])) u_digit (
            .clk      (clk),
            .rst      (rst),
            .inc      (inc[g]),
            .load     (ld[g]),
            .load_val (ld_val[g]),
            .q        (q_vec[g]),
            .carry    (carry[g])
        );
    end

    // 1pps watchdog: cleared by every 1pps, counts ms ticks otherwise and
    // saturates so pps_lost stays up during a long outage.
    always_ff @(posedge clk) begin
        if (rst)
            lost_cnt <= '0;
        else if (tsc_1pps)
            lost_cnt <= '0;
        else if (tsc_1ppms && lost_cnt != '1)
            lost_cnt <= lost_cnt + 11'd1;
    end

    assign pps_lost = (lost_cnt >= TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst)
            pps_err <= 1'b0;
        else
            pps_err <= snap;
    end

    // Set handshake: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            set_err <= 1'b0;
        end else begin
            state   <= state_next;
            set_err <= set_err_next;
        end
    end

    // Set handshake: next state.
    always_comb begin
        state_next   = state;
        set_err_next = set_err;
        case (state)
            IDLE: begin
                set_err_next = 1'b0;
                if (set_req) begin
                    if (set_ok) begin
                        state_next = ARM;
                    end else begin
                        state_next   = ACK;
                        set_err_next = 1'b1;
                    end
                end
            end
            ARM: begin
                if (!set_req) begin
                    state_next = IDLE;
                end else if (set_load) begin
                    state_next   = ACK;
                    set_err_next = 1'b0;
                end
            end
            ACK: begin
                if (!set_req) begin
                    state_next   = IDLE;
                    set_err_next = 1'b0;
                end
            end
            default: begin
                state_next   = IDLE;
                set_err_next = 1'b0;
            end
        endcase
    end

    // Set handshake: outputs. Without a 1pps reference any tick is accepted
    // as the load point so a set still completes.
    always_comb begin
        set_ack  = (state == ACK);
        set_load = (state == ARM) && set_req && (tsc_1pps || (pps_lost && tick));
    end

endmodule

// File: tb/tb_tod_cnt.sv
// Directed bench for tod_cnt: reset, ms roll, day wrap, 1pps snap, set
// handshake (valid and rejected), 1pps loss and recovery.
module tb_tod_cnt;
    import types_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  tsc_1ppms;
    logic  tsc_1pps;
    logic  set_req;
    time_t set_time;
    logic  set_ack;
    logic  set_err;
    time_t cur_time;
    logic  pps_err;
    logic  pps_lost;

    int    total = 0;
    int    bad   = 0;
    logic  err_seen;
    time_t st;

    tod_cnt #(.PPS_SYNC(1), .PPS_TIMEOUT(1100)) dut (
        .clk       (clk),
        .rst       (rst),
        .tsc_1ppms (tsc_1ppms),
        .tsc_1pps  (tsc_1pps),
        .set_req   (set_req),
        .set_time  (set_time),
        .set_ack   (set_ack),
        .set_err   (set_err),
        .cur_time  (cur_time),
        .pps_err   (pps_err),
        .pps_lost  (pps_lost)
    );

    always #5 clk = ~clk;

    function automatic time_t mk_time(input int h, input int m, input int s, input int ms);
        time_t t;
        t.t_10h   = 4'(h / 10);
        t.t_1h    = 4'(h % 10);
        t.t_10m   = 4'(m / 10);
        t.t_1m    = 4'(m % 10);
        t.t_10s   = 4'(s / 10);
        t.t_1s    = 4'(s % 10);
        t.t_100ms = 4'(ms / 100);
        t.t_10ms  = 4'((ms / 10) % 10);
        t.t_1ms   = 4'(ms % 10);
        return t;
    endfunction

    // Drive one cycle of tick inputs, then return 1 ns after the edge that
    // consumed them so outputs are sampled away from the clock edge.
    task automatic apply_stimulus(input logic ms, input logic pps);
        tsc_1ppms = ms;
        tsc_1pps  = pps;
        @(posedge clk);
        #1;
        tsc_1ppms = 1'b0;
        tsc_1pps  = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        tsc_1ppms = 1'b0;
        tsc_1pps  = 1'b0;
        set_req   = 1'b0;
        set_time  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_cur",      cur_time, mk_time(0, 0, 0, 0));
        check_output("rst_ack",      set_ack,  1'b0);
        check_output("rst_err",      set_err,  1'b0);
        check_output("rst_pps_err",  pps_err,  1'b0);
        check_output("rst_pps_lost", pps_lost, 1'b0);
        rst = 1'b0;

        $display("[TB] ms counting and normal 1pps roll");
        err_seen = 1'b0;
        for (int i = 0; i < 999; i++) begin
            apply_stimulus(1'b1, 1'b0);
            if (pps_err) err_seen = 1'b1;
        end
        check_output("t1_999", cur_time, mk_time(0, 0, 0, 999));
        apply_stimulus(1'b1, 1'b1);
        check_output("t1_roll",      cur_time, mk_time(0, 0, 1, 0));
        check_output("t1_no_pps_err", {err_seen, pps_err}, 2'b00);
        apply_stimulus(1'b0, 1'b0);
        check_output("t1_hold", cur_time, mk_time(0, 0, 1, 0));

        $display("[TB] set 00:00:05 then 1pps snap at .500");
        set_time = mk_time(0, 0, 5, 0);
        set_req  = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        check_output("t3_arm_ack", set_ack, 1'b0);
        apply_stimulus(1'b1, 1'b1);
        check_output("t3_load", cur_time, mk_time(0, 0, 5, 0));
        check_output("t3_ack",  set_ack,  1'b1);
        set_req = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        check_output("t3_ack_drop", set_ack, 1'b0);
        for (int i = 0; i < 500; i++) apply_stimulus(1'b1, 1'b0);
        check_output("t3_500", cur_time, mk_time(0, 0, 5, 500));
        apply_stimulus(1'b1, 1'b1);
        check_output("t3_snap",     cur_time, mk_time(0, 0, 6, 0));
        check_output("t3_pps_err",  pps_err,  1'b1);
        apply_stimulus(1'b0, 1'b0);
        check_output("t3_pps_err_1cyc", pps_err, 1'b0);

        $display("[TB] set 12:34:56 waits for 1pps");
        set_time = mk_time(12, 34, 56, 0);
        set_req  = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0);
        check_output("t4_wait_cur", cur_time, mk_time(0, 0, 6, 3));
        check_output("t4_wait_ack", set_ack,  1'b0);
        apply_stimulus(1'b1, 1'b1);
        check_output("t4_load",    cur_time, mk_time(12, 34, 56, 0));
        check_output("t4_ack",     {set_ack, set_err, pps_err}, 3'b100);
        set_req = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        check_output("t4_ack_drop", set_ack, 1'b0);

        $display("[TB] set 23:59:59 and day wrap");
        st = mk_time(23, 59, 59, 0);
        st.t_1ms   = 4'hF;
        st.t_100ms = 4'hC;
        set_time = st;
        set_req  = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1);
        check_output("t2_load", cur_time, mk_time(23, 59, 59, 0));
        check_output("t2_ack",  {set_ack, set_err}, 2'b10);
        set_req = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        for (int i = 0; i < 999; i++) apply_stimulus(1'b1, 1'b0);
        check_output("t2_999", cur_time, mk_time(23, 59, 59, 999));
        apply_stimulus(1'b1, 1'b1);
        check_output("t2_wrap",    cur_time, mk_time(0, 0, 0, 0));
        check_output("t2_pps_err", pps_err,  1'b0);

        $display("[TB] rejected set requests");
        set_time = mk_time(24, 0, 0, 0);
        set_req  = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        check_output("t5_h24_ack", {set_ack, set_err}, 2'b11);
        check_output("t5_h24_cur", cur_time, mk_time(0, 0, 0, 0));
        set_req = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        check_output("t5_h24_drop", {set_ack, set_err}, 2'b00);
        set_time = mk_time(0, 0, 60, 0);
        set_req  = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        check_output("t5_s60_ack", {set_ack, set_err}, 2'b11);
        apply_stimulus(1'b1, 1'b1);
        check_output("t5_s60_cur", cur_time, mk_time(0, 0, 1, 0));
        set_req = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        check_output("t5_s60_drop", {set_ack, set_err}, 2'b00);

        $display("[TB] 1pps loss, flywheel, set without 1pps, recovery");
        for (int i = 0; i < 1099; i++) apply_stimulus(1'b1, 1'b0);
        check_output("t6_lost_before", pps_lost, 1'b0);
        check_output("t6_cur_1099",    cur_time, mk_time(0, 0, 2, 99));
        apply_stimulus(1'b1, 1'b0);
        check_output("t6_lost",      pps_lost, 1'b1);
        check_output("t6_flywheel",  cur_time, mk_time(0, 0, 2, 100));
        set_time = mk_time(1, 2, 3, 0);
        set_req  = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        check_output("t6_arm_ack", set_ack, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        check_output("t6_load", cur_time, mk_time(1, 2, 3, 0));
        check_output("t6_ack",  {set_ack, set_err}, 2'b10);
        set_req = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1);
        check_output("t6_recover", pps_lost, 1'b0);
        check_output("t6_snap",    cur_time, mk_time(1, 2, 4, 0));
        check_output("t6_pps_err", pps_err,  1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
